// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: the transaction FSM state
// encoding and the requester index constants used to address the two-entry
// requester vectors (index 0 = I-cache refill, index 1 = D-cache refill/writeback).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    WRESP = 2'd3
  } arb_state_t;

  localparam int REQ_IC = 0;
  localparam int REQ_DC = 1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2
// Combinational two-way round-robin pick.
// Ports:
//   valid_i       requests present, indexed by requester
//   last_owner_i  requester granted most recently
//   grant_o       one-hot grant (or zero when nobody requests)
// A lone requester wins outright; on a tie the requester that did not own
// the port last time wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_owner_i,
  output logic [1:0] grant_o
);

  logic tie;

  assign tie = valid_i[REQ_IC] & valid_i[REQ_DC];

  always_comb begin
    grant_o         = '0;
    grant_o[REQ_IC] = valid_i[REQ_IC] & (~tie | (last_owner_i == 1'(REQ_DC)));
    grant_o[REQ_DC] = valid_i[REQ_DC] & (~tie | (last_owner_i == 1'(REQ_IC)));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one downstream memory port between the I-cache refill engine
// (requester 0) and the D-cache refill/writeback engine (requester 1).
// One transaction at a time: accept, issue, then either stream read beats
// back to the owner or wait for the write response.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/ready/addr/write/wdata   per-requester request channel
//   rsp_valid/last/done        per-requester response strobes (owner only)
//   rsp_rdata                  read beat data, shared by both requesters
//   m_req/ready/addr/write/wdata       memory request channel
//   m_rvalid/rdata/rlast       memory read beat channel
//   m_bvalid                   memory write response
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; the requester holds valid and fields stable
// until then. On the memory side the request transfers when m_req and
// m_ready are both high; m_addr/m_write/m_wdata stay stable while m_req is up.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                 req_write,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [1:0]                 rsp_last,
  output logic [1:0]                 rsp_done,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       m_req,
  input  logic                       m_ready,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic                       m_write,
  output logic [DATA_WIDTH-1:0]      m_wdata,
  input  logic                       m_rvalid,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic                       m_rlast,
  input  logic                       m_bvalid
);

  localparam int              CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t             state_q;
  logic                   last_owner_q;
  logic                   owner_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [CNT_W-1:0]       beat_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   write_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   m_req_q;
  // Sticky protocol error: read burst length disagreed with BEATS.
  // Kept internal; it has no effect on sequencing.
  logic                   proto_err_q;

  logic [1:0]             grant;
  logic                   handshake;
  logic                   new_owner;

  rr_arbiter2 u_rr (
    .valid_i      (req_valid),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  // Ready is offered only in IDLE; gating with reset keeps every output low
  // while reset is held, even if requesters are already asserting valid.
  assign req_ready  = ((state_q == IDLE) && !reset) ? grant : 2'b00;
  assign handshake  = |(req_valid & req_ready);
  assign new_owner  = grant[REQ_DC];
  assign beat_cnt_d = beat_cnt_q + 1'b1;

  assign m_req   = m_req_q;
  assign m_addr  = addr_q;
  assign m_write = write_q;
  assign m_wdata = wdata_q;

  // Responses pass straight through to the owner only, and only in the
  // matching phase; stray memory responses in other states are dropped.
  always_comb begin
    rsp_valid = '0;
    rsp_last  = '0;
    rsp_done  = '0;
    rsp_rdata = '0;
    if (state_q == RDATA) begin
      rsp_valid[owner_q] = m_rvalid;
      rsp_last[owner_q]  = m_rvalid & m_rlast;
      rsp_rdata          = m_rdata;
    end
    if (state_q == WRESP) begin
      rsp_done[owner_q] = m_bvalid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      m_req_q      <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            addr_q       <= req_addr[new_owner];
            write_q      <= req_write[new_owner];
            wdata_q      <= req_wdata[new_owner];
            owner_q      <= new_owner;
            last_owner_q <= new_owner;
            beat_cnt_q   <= '0;
            m_req_q      <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req_q <= 1'b0;
            state_q <= write_q ? WRESP : RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid) begin
            beat_cnt_q <= beat_cnt_d;
            // rlast must coincide exactly with the final counted beat; this
            // catches both an early rlast and a wrap with no rlast.
            if (m_rlast != (beat_cnt_q == LAST_BEAT)) begin
              proto_err_q <= 1'b1;
            end
            if (m_rlast) begin
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: reset state, single read, stalled
// write, round-robin ties, back-pressure, mid-transaction reset and an early
// rlast protocol error. Inputs change 1 time unit after the rising edge;
// outputs are sampled 3 time units after the rising edge.
module tb_mem_port_arbiter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0][63:0]  req_addr = '0;
  logic [1:0]        req_write = '0;
  logic [1:0][63:0]  req_wdata = '0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_last;
  logic [1:0]        rsp_done;
  logic [63:0]       rsp_rdata;
  logic              m_req;
  logic              m_ready = 1'b0;
  logic [63:0]       m_addr;
  logic              m_write;
  logic [63:0]       m_wdata;
  logic              m_rvalid = 1'b0;
  logic [63:0]       m_rdata = '0;
  logic              m_rlast = 1'b0;
  logic              m_bvalid = 1'b0;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BEATS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_last  (rsp_last),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .m_req     (m_req),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_write   (m_write),
    .m_wdata   (m_wdata),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_bvalid  (m_bvalid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Called while the DUT is in ISSUE: accept the memory request.
  task automatic issue_accept();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
  endtask

  // Feed n read beats, rlast on index last_at.
  task automatic serve_read(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = 64'hA000 + 64'(i);
      m_rlast  = (i == last_at);
      cyc();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    @(posedge clk);
    #3;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    checks++; if (m_addr !== 64'h0) begin failures++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
    checks++; if ({rsp_valid, rsp_last, rsp_done} !== 6'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=000000", {rsp_valid, rsp_last, rsp_done}); end
    req_valid = 2'b00;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    cyc();
    req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 64'h1000;
    settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL read_req_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00; req_addr[0] = 64'hFFFF;
    settle();
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL read_m_req got=%b exp=1", m_req); end
    checks++; if (m_addr !== 64'h1000) begin failures++; $display("FAIL read_m_addr got=%h exp=1000", m_addr); end
    checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL read_m_write got=%b exp=0", m_write); end
    issue_accept();
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rdata = 64'h100 + 64'(i); m_rlast = (i == 7);
      settle();
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL read_rsp_valid beat=%0d got=%b exp=01", i, rsp_valid); end
      checks++; if (rsp_rdata !== 64'h100 + 64'(i)) begin failures++; $display("FAIL read_rsp_rdata beat=%0d got=%h exp=%h", i, rsp_rdata, 64'h100 + 64'(i)); end
      checks++; if (rsp_last !== ((i == 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL read_rsp_last beat=%0d got=%b", i, rsp_last); end
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    checks++; if ({m_req, rsp_valid} !== 3'b000) begin failures++; $display("FAIL read_end_idle got=%b exp=000", {m_req, rsp_valid}); end
    checks++; if (dut.proto_err_q !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", dut.proto_err_q); end
  endtask

  task automatic test_write();
    cyc();
    req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 64'h2008; req_wdata[1] = 64'hDEADBEEF;
    settle();
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL write_req_ready got=%b exp=10", req_ready); end
    cyc();
    req_valid = 2'b00; req_write = 2'b00; req_addr[1] = '1; req_wdata[1] = '0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({m_req, m_write} !== 2'b11) begin failures++; $display("FAIL write_stall_req stall=%0d got=%b exp=11", k, {m_req, m_write}); end
      checks++; if (m_addr !== 64'h2008) begin failures++; $display("FAIL write_stall_addr stall=%0d got=%h exp=2008", k, m_addr); end
      checks++; if (m_wdata !== 64'hDEADBEEF) begin failures++; $display("FAIL write_stall_wdata stall=%0d got=%h exp=deadbeef", k, m_wdata); end
      cyc();
    end
    issue_accept();
    m_bvalid = 1'b1;
    settle();
    checks++; if (rsp_done !== 2'b10) begin failures++; $display("FAIL write_done got=%b exp=10", rsp_done); end
    cyc();
    m_bvalid = 1'b0;
    settle();
    checks++; if ({rsp_done, m_req} !== 3'b000) begin failures++; $display("FAIL write_done_pulse got=%b exp=000", {rsp_done, m_req}); end
  endtask

  task automatic test_tie();
    logic [1:0]  exp_ready;
    logic [63:0] exp_addr;
    apply_reset();
    cyc();
    req_valid = 2'b11; req_write = 2'b00; req_addr[0] = 64'h3000; req_addr[1] = 64'h4000;
    for (int g = 0; g < 4; g++) begin
      exp_ready = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (g % 2 == 0) ? 64'h3000 : 64'h4000;
      settle();
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL tie_grant n=%0d got=%b exp=%b", g, req_ready, exp_ready); end
      cyc();
      settle();
      checks++; if (m_addr !== exp_addr) begin failures++; $display("FAIL tie_addr n=%0d got=%h exp=%h", g, m_addr, exp_addr); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL tie_busy_ready n=%0d got=%b exp=00", g, req_ready); end
      issue_accept();
      serve_read(8, 7);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    cyc();
    req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 64'h5000;
    settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_ic_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b10; req_addr[1] = 64'h6000;
    issue_accept();
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rdata = 64'h600 + 64'(i); m_rlast = (i == 7);
      settle();
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_dc_ready beat=%0d got=%b exp=00", i, req_ready); end
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_rsp_owner beat=%0d got=%b exp=01", i, rsp_valid); end
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_dc_accept got=%b exp=10", req_ready); end
    cyc();
    req_valid = 2'b00;
    settle();
    checks++; if ({m_req, m_addr} !== {1'b1, 64'h6000}) begin failures++; $display("FAIL bp_dc_issue got=%b/%h exp=1/6000", m_req, m_addr); end
    issue_accept();
    m_rvalid = 1'b1; m_rdata = 64'h77; m_rlast = 1'b0;
    settle();
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_dc_rsp_owner got=%b exp=10", rsp_valid); end
    m_rvalid = 1'b0;
    cyc();
    serve_read(7, 6);
  endtask

  task automatic test_reset_mid();
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h7000; req_write = 2'b00;
    cyc();
    req_valid = 2'b00;
    issue_accept();
    serve_read(4, 99);
    m_rvalid = 1'b1; m_rdata = 64'h55; m_rlast = 1'b0;
    settle();
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rstmid_pre got=%b exp=01", rsp_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({rsp_valid, rsp_last, m_req, req_ready} !== 7'b0) begin failures++; $display("FAIL rstmid_async got=%b exp=0000000", {rsp_valid, rsp_last, m_req, req_ready}); end
    checks++; if (m_addr !== 64'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", m_addr); end
    cyc();
    reset = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({rsp_valid, rsp_last} !== 4'b0) begin failures++; $display("FAIL rstmid_stray n=%0d got=%b exp=0000", k, {rsp_valid, rsp_last}); end
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    req_valid = 2'b10; req_addr[1] = 64'h8000;
    settle();
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rstmid_new_ready got=%b exp=10", req_ready); end
    cyc();
    req_valid = 2'b00;
    settle();
    checks++; if ({m_req, m_addr} !== {1'b1, 64'h8000}) begin failures++; $display("FAIL rstmid_new_issue got=%b/%h exp=1/8000", m_req, m_addr); end
    issue_accept();
    serve_read(8, 7);
  endtask

  task automatic test_proto_err();
    apply_reset();
    settle();
    checks++; if (dut.proto_err_q !== 1'b0) begin failures++; $display("FAIL perr_reset got=%b exp=0", dut.proto_err_q); end
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h9000; req_write = 2'b00;
    cyc();
    req_valid = 2'b00;
    issue_accept();
    for (int i = 0; i < 6; i++) begin
      m_rvalid = 1'b1; m_rdata = 64'h900 + 64'(i); m_rlast = (i == 5);
      settle();
      checks++; if (rsp_last !== ((i == 5) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL perr_last beat=%0d got=%b", i, rsp_last); end
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    checks++; if (dut.proto_err_q !== 1'b1) begin failures++; $display("FAIL perr_flag got=%b exp=1", dut.proto_err_q); end
    cyc();
    req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL perr_idle_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    issue_accept();
    serve_read(8, 7);
    settle();
    checks++; if (dut.proto_err_q !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", dut.proto_err_q); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_proto_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
